// File: rtl/dmem_stall_ctrl.sv
// MEM-stage data-memory access controller: turns a load/store into a bus
// request/address/data handshake and freezes the pipeline while it is in flight.
module dmem_stall_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en,
    input  logic              mem_type,
    input  logic [1:0]        mem_size,
    input  logic              mem_signed,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_stall,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_addr_err,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic MEM_STORE = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ADDR = 2'b01,
        S_DATA = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t            state_q, state_d;
    logic              bus_wr_q, bus_wr_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;
    logic [1:0]        ld_size_q, ld_size_d;
    logic [1:0]        ld_off_q, ld_off_d;
    logic              ld_signed_q, ld_signed_d;

    logic              misalign_s;
    logic              start_s;
    logic [3:0]        be_s;
    logic [DATA_W-1:0] wdata_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [DATA_W-1:0] ext_s;

    // Alignment / reserved-size check and request-field formatting
    always_comb begin
        misalign_s = 1'b0;
        be_s       = 4'b0000;
        wdata_s    = mem_wdata;
        case (mem_size)
            2'b00: begin
                misalign_s = 1'b0;
                be_s       = 4'b0001 << mem_addr[1:0];
                wdata_s    = {4{mem_wdata[7:0]}};
            end
            2'b01: begin
                misalign_s = mem_addr[0];
                be_s       = mem_addr[1] ? 4'b1100 : 4'b0011;
                wdata_s    = {2{mem_wdata[15:0]}};
            end
            2'b10: begin
                misalign_s = |mem_addr[1:0];
                be_s       = 4'b1111;
                wdata_s    = mem_wdata;
            end
            default: begin
                misalign_s = 1'b1;
                be_s       = 4'b0000;
                wdata_s    = mem_wdata;
            end
        endcase
        mem_addr_err = mem_en & misalign_s;
        start_s      = (state_q == S_IDLE) & mem_en & ~misalign_s;
    end

    // Load lane extraction and sign/zero extension from the captured access shape
    always_comb begin
        byte_s = bus_rdata[{ld_off_q, 3'b000} +: 8];
        half_s = bus_rdata[{ld_off_q[1], 4'b0000} +: 16];
        case (ld_size_q)
            2'b00:   ext_s = {{24{ld_signed_q & byte_s[7]}}, byte_s};
            2'b01:   ext_s = {{16{ld_signed_q & half_s[15]}}, half_s};
            default: ext_s = bus_rdata;
        endcase
    end

    // Next-state, request-field capture and load-result update
    always_comb begin
        state_d     = state_q;
        bus_wr_d    = bus_wr_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        ld_size_d   = ld_size_q;
        ld_off_d    = ld_off_q;
        ld_signed_d = ld_signed_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) begin
                    state_d     = S_ADDR;
                    bus_wr_d    = (mem_type == MEM_STORE);
                    bus_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
                    bus_be_d    = be_s;
                    bus_wdata_d = wdata_s;
                    ld_size_d   = mem_size;
                    ld_off_d    = mem_addr[1:0];
                    ld_signed_d = mem_signed;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (bus_addr_ok) begin
                    state_d = S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                if (bus_data_ok) begin
                    state_d = S_DONE;
                    if (!bus_wr_q) begin
                        mem_rdata_d = ext_s;
                    end else begin
                        mem_rdata_d = mem_rdata_q;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            // DONE lets the completed instruction advance without being reissued
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and request-field registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bus_wr_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= '0;
            mem_rdata_q <= '0;
            ld_size_q   <= 2'b00;
            ld_off_q    <= 2'b00;
            ld_signed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_wr_q    <= bus_wr_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            mem_rdata_q <= mem_rdata_d;
            ld_size_q   <= ld_size_d;
            ld_off_q    <= ld_off_d;
            ld_signed_q <= ld_signed_d;
        end
    end

    assign mem_stall = start_s | (state_q == S_ADDR) | (state_q == S_DATA);
    assign bus_req   = (state_q == S_ADDR);
    assign bus_wr    = bus_wr_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;
    assign mem_rdata = mem_rdata_q;

endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// Directed self-checking bench for dmem_stall_ctrl with a scripted bus responder.
module tb_dmem_stall_ctrl;

    localparam logic LD = 1'b0;
    localparam logic ST = 1'b1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_en = 1'b0, mem_type = LD, mem_signed = 1'b0;
    logic [1:0]  mem_size = 2'b10;
    logic [31:0] mem_addr = 32'h0, mem_wdata = 32'h0;
    logic        mem_stall, mem_addr_err;
    logic [31:0] mem_rdata;
    logic        bus_req, bus_wr;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_stall_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .mem_en(mem_en), .mem_type(mem_type),
        .mem_size(mem_size), .mem_signed(mem_signed), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_stall(mem_stall), .mem_rdata(mem_rdata),
        .mem_addr_err(mem_addr_err), .bus_req(bus_req), .bus_wr(bus_wr),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic typ, input logic [1:0] sz, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        mem_en = 1'b1; mem_type = typ; mem_size = sz; mem_signed = sgn;
        mem_addr = addr; mem_wdata = wd;
        #1;
    endtask

    // Plays the bus side of one transfer; returns on the DONE cycle (mem_en dropped there)
    task automatic run_xfer(input int a_dly, input int d_dly, input logic [31:0] rd,
                            output int n_stall, output int n_req, output logic stable,
                            output logic [3:0] be, output logic [31:0] addr,
                            output logic wr, output logic [31:0] wd);
        int   a_cnt = 0, d_cnt = 0;
        logic in_data = 1'b0, data_given = 1'b0, done = 1'b0;
        n_stall = 0; n_req = 0; stable = 1'b1;
        be = 4'h0; addr = 32'h0; wr = 1'b0; wd = 32'h0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                #1;
            end
            bus_addr_ok = 1'b0;
            bus_data_ok = 1'b0;
            bus_rdata   = ~rd;
            if (data_given && !mem_stall) begin
                done   = 1'b1;
                mem_en = 1'b0;
            end else begin
                if (mem_stall) n_stall++;
                if (bus_req) begin
                    if (n_req == 0) begin
                        be = bus_be; addr = bus_addr; wr = bus_wr; wd = bus_wdata;
                    end else if (bus_be !== be || bus_addr !== addr ||
                                 bus_wr !== wr || bus_wdata !== wd) begin
                        stable = 1'b0;
                    end
                    n_req++;
                    if (a_cnt == a_dly) begin
                        bus_addr_ok = 1'b1;
                        in_data     = 1'b1;
                    end
                    a_cnt++;
                end else if (in_data) begin
                    if (d_cnt == d_dly) begin
                        bus_data_ok = 1'b1;
                        bus_rdata   = rd;
                        data_given  = 1'b1;
                        in_data     = 1'b0;
                    end
                    d_cnt++;
                end
            end
        end
        check_eq("xfer_reached_done", {31'd0, done}, 32'd1);
    endtask

    // Cycle after DONE: nothing reissued, pipeline free
    task automatic check_idle_after(input string tag);
        @(negedge clk);
        #1;
        check_eq({tag, "_no_reissue_req"}, {31'd0, bus_req}, 32'd0);
        check_eq({tag, "_no_reissue_stall"}, {31'd0, mem_stall}, 32'd0);
    endtask

    int          ns, nr;
    logic        stb, wr_o;
    logic [3:0]  be_o;
    logic [31:0] addr_o, wd_o;
    int          req_seen;

    initial begin
        #2;
        check_eq("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check_eq("rst_bus_be", {28'd0, bus_be}, 32'd0);
        check_eq("rst_bus_addr", bus_addr, 32'd0);
        check_eq("rst_mem_rdata", mem_rdata, 32'd0);
        check_eq("rst_stall", {31'd0, mem_stall}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Word load, minimum latency
        issue(LD, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        run_xfer(0, 0, 32'hDEAD_BEEF, ns, nr, stb, be_o, addr_o, wr_o, wd_o);
        check_eq("wl_stall_cycles", ns, 32'd3);
        check_eq("wl_req_cycles", nr, 32'd1);
        check_eq("wl_be", {28'd0, be_o}, 32'h0000_000F);
        check_eq("wl_addr", addr_o, 32'h0000_0100);
        check_eq("wl_wr", {31'd0, wr_o}, 32'd0);
        check_eq("wl_rdata", mem_rdata, 32'hDEAD_BEEF);
        check_idle_after("wl");

        // Signed then unsigned byte load from the top lane
        issue(LD, 2'b00, 1'b1, 32'h0000_0103, 32'h0);
        run_xfer(0, 0, 32'h8011_2233, ns, nr, stb, be_o, addr_o, wr_o, wd_o);
        check_eq("sb_be", {28'd0, be_o}, 32'h0000_0008);
        check_eq("sb_addr", addr_o, 32'h0000_0100);
        check_eq("sb_rdata", mem_rdata, 32'hFFFF_FF80);
        issue(LD, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        run_xfer(0, 0, 32'h8011_2233, ns, nr, stb, be_o, addr_o, wr_o, wd_o);
        check_eq("ub_rdata", mem_rdata, 32'h0000_0080);

        // Signed half load from the upper lane
        issue(LD, 2'b01, 1'b1, 32'h0000_0012, 32'h0);
        run_xfer(0, 0, 32'h9ABC_0011, ns, nr, stb, be_o, addr_o, wr_o, wd_o);
        check_eq("sh_be", {28'd0, be_o}, 32'h0000_000C);
        check_eq("sh_rdata", mem_rdata, 32'hFFFF_9ABC);

        // Half store to the upper lane leaves mem_rdata alone
        issue(ST, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD);
        run_xfer(0, 0, 32'h1234_5678, ns, nr, stb, be_o, addr_o, wr_o, wd_o);
        check_eq("hs_wr", {31'd0, wr_o}, 32'd1);
        check_eq("hs_be", {28'd0, be_o}, 32'h0000_000C);
        check_eq("hs_wdata", wd_o, 32'hABCD_ABCD);
        check_eq("hs_addr", addr_o, 32'h0000_0200);
        check_eq("hs_rdata_kept", mem_rdata, 32'hFFFF_9ABC);

        // Byte store in lane 1 replicates the byte
        issue(ST, 2'b00, 1'b0, 32'h0000_0301, 32'h1234_56A5);
        run_xfer(0, 0, 32'h0, ns, nr, stb, be_o, addr_o, wr_o, wd_o);
        check_eq("bs_be", {28'd0, be_o}, 32'h0000_0002);
        check_eq("bs_wdata", wd_o, 32'hA5A5_A5A5);

        // Misaligned and reserved-size accesses are rejected without a transfer
        issue(LD, 2'b10, 1'b0, 32'h0000_0101, 32'h0);
        check_eq("err_word_flag", {31'd0, mem_addr_err}, 32'd1);
        check_eq("err_word_stall", {31'd0, mem_stall}, 32'd0);
        req_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (bus_req) req_seen++;
        end
        check_eq("err_word_no_req", req_seen, 32'd0);
        mem_size = 2'b01; mem_addr = 32'h0000_0103;
        #1;
        check_eq("err_half_flag", {31'd0, mem_addr_err}, 32'd1);
        mem_size = 2'b11; mem_addr = 32'h0000_0100;
        #1;
        check_eq("err_rsvd_flag", {31'd0, mem_addr_err}, 32'd1);
        check_eq("err_rsvd_stall", {31'd0, mem_stall}, 32'd0);
        mem_size = 2'b01; mem_addr = 32'h0000_0102;
        #1;
        check_eq("ok_half_flag", {31'd0, mem_addr_err}, 32'd0);
        mem_en = 1'b0;

        // Slow bus: addr_ok after 4 waits, data_ok after 3 waits
        issue(LD, 2'b10, 1'b0, 32'h0000_03FC, 32'h0);
        run_xfer(4, 3, 32'h1234_5678, ns, nr, stb, be_o, addr_o, wr_o, wd_o);
        check_eq("slow_req_cycles", nr, 32'd5);
        check_eq("slow_stall_cycles", ns, 32'd10);
        check_eq("slow_fields_stable", {31'd0, stb}, 32'd1);
        check_eq("slow_rdata", mem_rdata, 32'h1234_5678);
        check_idle_after("slow");

        // Reset during DATA, then a stale data_ok
        issue(LD, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        @(negedge clk);
        #1;
        check_eq("rstx_req_in_addr", {31'd0, bus_req}, 32'd1);
        bus_addr_ok = 1'b1;
        @(negedge clk);
        #1;
        bus_addr_ok = 1'b0;
        check_eq("rstx_in_data_stall", {31'd0, mem_stall}, 32'd1);
        check_eq("rstx_in_data_req", {31'd0, bus_req}, 32'd0);
        mem_en = 1'b0;
        rst    = 1'b1;
        #1;
        check_eq("rstx_req_low", {31'd0, bus_req}, 32'd0);
        check_eq("rstx_rdata_clr", mem_rdata, 32'd0);
        check_eq("rstx_be_clr", {28'd0, bus_be}, 32'd0);
        @(negedge clk);
        rst         = 1'b0;
        bus_data_ok = 1'b1;
        bus_rdata   = 32'hBAD0_BAD0;
        @(negedge clk);
        #1;
        bus_data_ok = 1'b0;
        check_eq("rstx_stray_stall", {31'd0, mem_stall}, 32'd0);
        check_eq("rstx_stray_req", {31'd0, bus_req}, 32'd0);
        check_eq("rstx_stray_rdata", mem_rdata, 32'd0);
        issue(LD, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        run_xfer(1, 0, 32'h0BAD_F00D, ns, nr, stb, be_o, addr_o, wr_o, wd_o);
        check_eq("rstx_next_stall", ns, 32'd4);
        check_eq("rstx_next_addr", addr_o, 32'h0000_0400);
        check_eq("rstx_next_rdata", mem_rdata, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_stall_ctrl.md
Name: dmem_stall_ctrl

Overview:
- MEM-stage data-memory access controller: it converts the MEM-stage load/store request into a request/address/data handshake on the data bus.
- It generates the mem_stall signal consumed by the pipeline hazard/enable logic, which freezes all four pipeline registers while a transfer is in flight.
- It performs byte-enable generation, store-data lane replication, load lane extraction and sign/zero extension, and alignment checking.

Parameters:
- ADDR_W, 32, width of mem_addr and bus_addr.
- DATA_W, 32, data width (fixed at 32; byte lanes = 4).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_en  in  1  MEM stage holds a valid load or store this cycle.
- mem_type  in  1  `MEM_LOAD / `MEM_STORE (common.vh encoding).
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_signed  in  1  load sign-extends when 1, zero-extends when 0.
- mem_addr  in  ADDR_W  byte address.
- mem_wdata  in  32  store data, right-aligned.
- mem_stall  out  1  freeze request to the pipeline enable logic.
- mem_rdata  out  32  extended load result.
- mem_addr_err  out  1  misaligned or reserved-size access.
- bus_req  out  1  transfer request.
- bus_wr  out  1  1 = write.
- bus_addr  out  ADDR_W  word-aligned address (low 2 bits forced to 0).
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_addr_ok  in  1  request accepted this cycle.
- bus_data_ok  in  1  read data valid / write complete this cycle.
- bus_rdata  in  32  read data.

Behaviour:
- Error and stall logic:
  - mem_addr_err (combinational) = mem_en & (size 11 | half with addr[0] | word with addr[1:0]≠0).
  - When mem_addr_err is set: no transfer, no stall, FSM stays IDLE.
- FSM states: IDLE, ADDR, DATA, DONE. Reset state is IDLE.
  - IDLE: if mem_en & !mem_addr_err → ADDR; otherwise stay in IDLE.
  - ADDR: bus_req=1. Transition to DATA on bus_addr_ok.
  - DATA: bus_req=0. Transition to DONE on bus_data_ok. For loads, register the extended bus_rdata into mem_rdata on this edge.
  - DONE: transition to IDLE unconditionally. This state prevents reissue while the completed instruction is still presented during its advance cycle.
- mem_stall (combinational) = (IDLE & mem_en & !mem_addr_err) | ADDR | DATA. It is 0 in DONE, so the pipeline advances exactly once per transfer.
- Request-field registration:
  - bus_wr, bus_addr, bus_be and bus_wdata are registered on the IDLE→ADDR edge.
  - They are held constant through ADDR and DATA.
  - The bus may rely on these fields being stable while bus_req is high.
- Byte enables:
  - Byte: 4'b0001 << addr[1:0].
  - Half: 0011 if addr[1]=0, otherwise 1100.
  - Word: 1111.
- bus_wdata lane replication:
  - Byte: {4{wdata[7:0]}}.
  - Half: {2{wdata[15:0]}}.
  - Word: wdata.
- Load extraction:
  - Select the byte at rdata[8*addr[1:0]+:8], or the half at rdata[16*addr[1]+:16].
  - Extend to 32 bits per mem_signed.
  - Word loads pass rdata unchanged.
  - Stores leave mem_rdata unchanged.
- mem_rdata validity: valid from DONE onward; held until the next load completes.
- Minimum latency: the first stall cycle is in IDLE. With addr_ok and data_ok each in the first cycle they are sampled, there are 3 stall cycles before the DONE cycle.
- Bus response timing:
  - bus_addr_ok is ignored outside ADDR.
  - bus_data_ok is ignored outside DATA, including a stale response arriving after reset.
  - addr_ok and data_ok for the same transfer never coincide. data_ok is sampled only in DATA, from the cycle after acceptance.
- Reset values (all applied asynchronously):
  - state=IDLE, bus_req=0, bus_wr=0, bus_addr=0, bus_be=0, bus_wdata=0, mem_rdata=0.
  - mem_stall follows its combinational equation.
  - A reset mid-transfer abandons the transfer; bus_req drops immediately.
- Inputs while stalled: mem_* inputs are stable while mem_stall=1 because the pipeline is frozen. The block does not re-sample them after the IDLE→ADDR edge.

Test Plan:
- Word load, addr=0x100, addr_ok and data_ok each in the first cycle sampled, rdata=0xDEADBEEF → bus_be=1111, bus_addr=0x100, mem_stall high 3 cycles then low 1 cycle, mem_rdata=0xDEADBEEF.
- Signed byte load at 0x103, rdata=0x80112233 → be=1000, mem_rdata=0xFFFFFF80. With mem_signed=0 → mem_rdata=0x00000080.
- Half store at 0x202, wdata=0x0000ABCD → bus_wr=1, be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200.
- Word load at 0x101 → mem_addr_err=1, mem_stall=0, bus_req never asserted.
- addr_ok delayed 4 cycles, data_ok delayed 3 cycles → bus_req high 5 cycles with fields constant, stall high 1+5+4 cycles, exactly one DONE cycle, no reissue.
- rst pulsed while in DATA, then data_ok arrives → state IDLE, bus_req=0, mem_rdata=0, stray data_ok ignored, next request proceeds normally.
